// File: rtl/led_seq_pkg.sv
// Shared types and widths for the LED pattern sequencer.
// Mode encodings, bounce direction and initial LED value per mode.
package led_seq_pkg;

    localparam int unsigned LED_W = 4;
    localparam int unsigned SPD_W = 5;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // LED value loaded when a mode is entered
    function automatic logic [LED_W-1:0] mode_init_led(input mode_e m);
        logic [LED_W-1:0] v;
        v = '0;
        if (m == MODE_CHASE || m == MODE_BOUNCE) begin
            v = LED_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider with a saturating tap selector; emits a one-cycle tick
// on each rising edge of the selected tap, masked for one cycle after a tap switch.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 30,
    parameter int unsigned SPEED_MIN     = 0,
    parameter int unsigned SPEED_MAX     = 29,
    parameter int unsigned SPEED_DEFAULT = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fast_pulse,
    input  logic             slow_pulse,
    output logic [SPD_W-1:0] speed_sel,
    output logic             tick
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [SPD_W-1:0]     r_speed_sel;
    logic                 r_tap_q;
    logic                 r_spd_chg_q;
    logic                 r_tick;

    logic [SPD_W-1:0]     w_speed_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_shr;
    logic                 w_tap;

    // Saturating speed update; simultaneous fast and slow cancel out
    always_comb begin
        w_speed_nxt = r_speed_sel;
        if (fast_pulse && !slow_pulse && (r_speed_sel != SPD_W'(SPEED_MIN))) begin
            w_speed_nxt = r_speed_sel - SPD_W'(1);
        end else if (slow_pulse && !fast_pulse && (r_speed_sel != SPD_W'(SPEED_MAX))) begin
            w_speed_nxt = r_speed_sel + SPD_W'(1);
        end
    end

    // Shift-then-pick avoids an index wider than the counter
    assign w_cnt_shr = r_cnt >> r_speed_sel;
    assign w_tap     = w_cnt_shr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_speed_sel <= SPD_W'(SPEED_DEFAULT);
            r_tap_q     <= 1'b0;
            r_spd_chg_q <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_cnt       <= r_cnt + CNT_WIDTH'(1);
            r_speed_sel <= w_speed_nxt;
            r_spd_chg_q <= (w_speed_nxt != r_speed_sel);
            r_tap_q     <= w_tap;
            r_tick      <= w_tap & ~r_tap_q & ~r_spd_chg_q;
        end
    end

    assign speed_sel = r_speed_sel;
    assign tick      = r_tick;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives the 4-bit LED bank: mode FSM stepped by key pulses, pattern advanced
// on each divider tick from led_tick_gen.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 30,
    parameter int unsigned SPEED_MIN     = 0,
    parameter int unsigned SPEED_MAX     = 29,
    parameter int unsigned SPEED_DEFAULT = 23
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fast_pulse,
    input  logic             slow_pulse,
    input  logic             mode_pulse,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic [SPD_W-1:0] speed_sel,
    output logic             tick
);

    mode_e            r_mode;
    mode_e            w_mode_nxt;
    dir_e             r_dir;
    dir_e             w_dir_nxt;
    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_led_nxt;

    logic             w_tick;
    logic [SPD_W-1:0] w_speed_sel;

    led_tick_gen #(
        .CNT_WIDTH     (CNT_WIDTH),
        .SPEED_MIN     (SPEED_MIN),
        .SPEED_MAX     (SPEED_MAX),
        .SPEED_DEFAULT (SPEED_DEFAULT)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .fast_pulse (fast_pulse),
        .slow_pulse (slow_pulse),
        .speed_sel  (w_speed_sel),
        .tick       (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_BLINK;
            r_dir  <= DIR_LEFT;
            r_led  <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_dir  <= w_dir_nxt;
            r_led  <= w_led_nxt;
        end
    end

    // Mode change wins over a coincident tick, which is dropped
    always_comb begin
        w_mode_nxt = r_mode;
        w_dir_nxt  = r_dir;
        w_led_nxt  = r_led;
        if (mode_pulse) begin
            case (r_mode)
                MODE_BLINK:  w_mode_nxt = MODE_CHASE;
                MODE_CHASE:  w_mode_nxt = MODE_BOUNCE;
                MODE_BOUNCE: w_mode_nxt = MODE_COUNT;
                MODE_COUNT:  w_mode_nxt = MODE_BLINK;
                default:     w_mode_nxt = MODE_BLINK;
            endcase
            w_dir_nxt = DIR_LEFT;
            w_led_nxt = mode_init_led(w_mode_nxt);
        end else if (w_tick) begin
            case (r_mode)
                MODE_BLINK: w_led_nxt = ~r_led;
                MODE_CHASE: w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
                MODE_BOUNCE: begin
                    // Reverse at either end; the end LED is shown once per sweep
                    if (r_dir == DIR_LEFT) begin
                        if (r_led[LED_W-1]) begin
                            w_dir_nxt = DIR_RIGHT;
                            w_led_nxt = r_led >> 1;
                        end else begin
                            w_led_nxt = r_led << 1;
                        end
                    end else begin
                        if (r_led[0]) begin
                            w_dir_nxt = DIR_LEFT;
                            w_led_nxt = r_led << 1;
                        end else begin
                            w_led_nxt = r_led >> 1;
                        end
                    end
                end
                MODE_COUNT: w_led_nxt = r_led + LED_W'(1);
                default: begin
                    w_mode_nxt = MODE_BLINK;
                    w_dir_nxt  = DIR_LEFT;
                    w_led_nxt  = '0;
                end
            endcase
        end
    end

    assign led       = r_led;
    assign mode      = 2'(r_mode);
    assign speed_sel = w_speed_sel;
    assign tick      = w_tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed scenarios plus random
// key traffic, compared every cycle against an arithmetic reference model.
module tb_led_pattern_sequencer;

    localparam int unsigned CW   = 8;
    localparam int unsigned SMAX = 6;
    localparam int unsigned SDEF = 2;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       fast_pulse = 1'b0;
    logic       slow_pulse = 1'b0;
    logic       mode_pulse = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic [4:0] speed_sel;
    logic       tick;

    int checks = 0;
    int errors = 0;

    // Reference model state for the current cycle
    int m_cnt, m_spd, m_mode, m_led, m_pos;
    bit m_chg, m_tick;
    int bseq[6]      = '{1, 2, 4, 8, 4, 2};
    int chase_exp[4] = '{2, 4, 8, 1};
    int bnc_exp[7]   = '{2, 4, 8, 4, 2, 1, 2};
    int fast_exp[5]  = '{1, 0, 0, 0, 0};

    led_pattern_sequencer #(
        .CNT_WIDTH     (CW),
        .SPEED_MIN     (0),
        .SPEED_MAX     (SMAX),
        .SPEED_DEFAULT (SDEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fast_pulse (fast_pulse),
        .slow_pulse (slow_pulse),
        .mode_pulse (mode_pulse),
        .led        (led),
        .mode       (mode),
        .speed_sel  (speed_sel),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_spd = SDEF; m_chg = 0; m_tick = 0;
        m_mode = 0; m_led = 0; m_pos = 0;
    endtask

    // Advance the model across one clock edge given this cycle's inputs
    task automatic model_step(input bit f, input bit s, input bit mp);
        int half;
        int ns;
        bit nt;
        half = 1 << m_spd;
        nt   = ((m_cnt % (2 * half)) == half) && !m_chg;
        ns   = m_spd;
        if (f && !s && m_spd > 0) ns = m_spd - 1;
        else if (s && !f && m_spd < int'(SMAX)) ns = m_spd + 1;
        if (mp) begin
            m_mode = (m_mode + 1) % 4;
            m_pos  = 0;
            m_led  = (m_mode == 1 || m_mode == 2) ? 1 : 0;
        end else if (m_tick) begin
            case (m_mode)
                0: m_led = ~m_led & 15;
                1: m_led = ((m_led << 1) | (m_led >> 3)) & 15;
                2: begin m_pos = (m_pos + 1) % 6; m_led = bseq[m_pos]; end
                default: m_led = (m_led + 1) & 15;
            endcase
        end
        m_chg  = (ns != m_spd);
        m_spd  = ns;
        m_tick = nt;
        m_cnt  = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic check_outputs();
        check("tick", tick, m_tick);
        check("led", led, m_led);
        check("mode", mode, m_mode);
        check("speed_sel", speed_sel, m_spd);
    endtask

    // Check this cycle, drive inputs, advance one clock
    task automatic cycle(input bit f = 1'b0, input bit s = 1'b0, input bit mp = 1'b0);
        check_outputs();
        fast_pulse = f; slow_pulse = s; mode_pulse = mp;
        model_step(f, s, mp);
        @(posedge clk);
        #1;
        fast_pulse = 1'b0; slow_pulse = 1'b0; mode_pulse = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tick", tick, 0);
        check("rst_led", led, 0);
        check("rst_mode", mode, 0);
        check("rst_speed", speed_sel, SDEF);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Wait for a tick, step past it, return the LED value that follows
    task automatic next_tick_led(output logic [3:0] v);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 400) begin
            cycle();
            n++;
        end
        check("tick_timeout", 32'(n < 400), 1);
        cycle();
        v = led;
    endtask

    task automatic tick_interval(output int n);
        logic [3:0] v;
        next_tick_led(v);
        n = 1;
        while (tick !== 1'b1 && n < 400) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        logic [3:0] v;
        int n;

        // Blink at default speed: first tick 5 cycles after release
        do_reset();
        repeat (5) cycle();
        check("t1_first_tick", tick, 1);
        check("t1_led_pre", led, 0);
        cycle();
        check("t1_led_on", led, 15);
        next_tick_led(v);
        check("t1_led_off", v, 0);

        // Chase
        do_reset();
        cycle(0, 0, 1);
        check("t2_mode", mode, 1);
        check("t2_led", led, 1);
        for (int i = 0; i < 4; i++) begin
            next_tick_led(v);
            check("t2_chase", v, chase_exp[i]);
        end

        // Bounce
        do_reset();
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        check("t3_mode", mode, 2);
        for (int i = 0; i < 7; i++) begin
            next_tick_led(v);
            check("t3_bounce", v, bnc_exp[i]);
        end

        // Speed saturation both ways, period at slowest
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0);
            check("t4_fast", speed_sel, fast_exp[i]);
        end
        repeat (8) cycle(0, 1, 0);
        check("t4_slow_sat", speed_sel, SMAX);
        tick_interval(n);
        check("t4_period", n, 128);
        cycle(1, 1, 0);
        check("t4_both", speed_sel, SMAX);

        // Tap switch that looks like a rising edge must not tick
        do_reset();
        n = 0;
        while (!((m_cnt % 16) == 8 && !m_chg) && n < 100) begin
            cycle();
            n++;
        end
        cycle(0, 1, 0);
        cycle();
        check("t5_no_spurious", tick, 0);
        tick_interval(n);
        check("t5_period", n, 16);

        // Mode pulse coincident with tick in COUNT at 0101
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        repeat (3) cycle(0, 0, 1);
        n = 0;
        while (!(m_led == 5 && m_tick) && n < 200) begin
            cycle();
            n++;
        end
        check("t6_setup", led, 5);
        cycle(0, 0, 1);
        check("t6_mode", mode, 0);
        check("t6_led", led, 0);
        n = 0;
        while (m_led == 0 && n < 50) begin
            cycle();
            n++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_led", led, 0);
        check("t6_async_mode", mode, 0);
        check("t6_async_speed", speed_sel, SDEF);
        check("t6_async_tick", tick, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (20) cycle();

        // Random key traffic
        do_reset();
        repeat (3000) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 31) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
